ctech_lib_sync_filter: RTL and testbench

// - Parametrised successor to the fixed triple-flop sync cell: WIDTH-bit async-to-clk synchronizer.
// - Adds configurable depth, async reset to a known value, a per-bit stability (glitch) filter,
//   and optional single-cycle edge pulses.
// - Sits at every async input / CDC level crossing into the clk domain.

---
 rtl/ctech_lib_sync_pkg.sv | 33 +++
 rtl/ctech_lib_sync_chain.sv | 42 ++++
 rtl/ctech_lib_sync_filter.sv | 105 ++++++++++
 tb/tb_ctech_lib_sync_filter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctech_lib_sync_pkg.sv
// ---------------------------------------------------------------------------
// ctech_lib_sync_pkg
// Shared types and limits for the ctech_lib_sync_filter family.
//   edge_mode_e : which transitions of the filtered level produce a pulse
//   MIN_STAGES / MAX_STAGES : legal synchronizer depth range
//   edge_pulse() : single-bit pulse decode for a given edge mode
// ---------------------------------------------------------------------------
package ctech_lib_sync_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        BOTH = 2'd3
    } edge_mode_e;

    localparam int MIN_STAGES = 2;
    localparam int MAX_STAGES = 4;

    // Pulse for one bit given its current and previous filtered level.
    function automatic logic edge_pulse(edge_mode_e mode, logic cur, logic prev);
        logic res;
        res = 1'b0;
        case (mode)
            RISE:    res = cur & ~prev;
            FALL:    res = ~cur & prev;
            BOTH:    res = cur ^ prev;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctech_lib_sync_chain.sv
// ---------------------------------------------------------------------------
// ctech_lib_sync_chain
// The clock-domain-crossing synchronizer proper: WIDTH independent flop
// chains of depth STAGES, asynchronously reset to RST_VAL. This module is
// the only place where the asynchronous inputs are sampled, so it is the
// boundary CDC review should recognise as the synchronizer.
// Ports:
//   clk     in   sampling clock
//   rst     in   asynchronous reset, active-high
//   i_d     in   WIDTH async inputs
//   o_sync  out  WIDTH synchronized bits (last flop of each chain)
// ---------------------------------------------------------------------------
module ctech_lib_sync_chain #(
    parameter int   WIDTH   = 1,
    parameter int   STAGES  = 3,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // Shift register: stage 0 captures the async input, later stages resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= {WIDTH{RST_VAL}};
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/ctech_lib_sync_filter.sv
// ---------------------------------------------------------------------------
// ctech_lib_sync_filter
// WIDTH-bit async-to-clk synchronizer with configurable depth, optional
// per-bit stability filter and optional single-cycle edge pulses.
// Ports:
//   clk      in   sampling clock
//   rst      in   asynchronous reset, active-high
//   d        in   WIDTH async inputs
//   o        out  WIDTH synchronized, filtered level
//   pulse    out  WIDTH one-cycle pulse per qualifying o transition
//   changed  out  OR of pulse
// With FILTER_CYCLES=0 the output is the last sync flop directly; otherwise
// a bit must disagree with o for FILTER_CYCLES consecutive clocks to flip.
// ---------------------------------------------------------------------------
module ctech_lib_sync_filter
    import ctech_lib_sync_pkg::*;
#(
    parameter int         WIDTH         = 1,
    parameter int         STAGES        = 3,
    parameter logic       RST_VAL       = 1'b0,
    parameter int         FILTER_CYCLES = 0,
    parameter edge_mode_e EDGE_MODE     = NONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] pulse,
    output logic             changed
);

    if ((STAGES < MIN_STAGES) || (STAGES > MAX_STAGES)) begin : g_bad_stages
        $error("ctech_lib_sync_filter: STAGES=%0d outside legal range %0d..%0d",
               STAGES, MIN_STAGES, MAX_STAGES);
    end

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_o;
    logic [WIDTH-1:0] w_pulse;
    logic [WIDTH-1:0] r_o_d;

    ctech_lib_sync_chain #(
        .WIDTH   (WIDTH),
        .STAGES  (STAGES),
        .RST_VAL (RST_VAL)
    ) u_chain (
        .clk    (clk),
        .rst    (rst),
        .i_d    (d),
        .o_sync (w_sync)
    );

    if (FILTER_CYCLES == 0) begin : g_nofilt
        assign w_o = w_sync;
    end else begin : g_filt
        localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
        localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            logic [CNT_W-1:0] r_cnt;
            logic             r_o;

            // Stability counter: any agreement with o restarts the count, so
            // only an unbroken run of FILTER_CYCLES differing samples flips o.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_o   <= RST_VAL;
                end else if (w_sync[b] == r_o) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_o   <= w_sync[b];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end

            assign w_o[b] = r_o;
        end
    end

    // Previous filtered level, used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_d <= {WIDTH{RST_VAL}};
        end else begin
            r_o_d <= w_o;
        end
    end

    // Per-bit edge decode; o and r_o_d are both flop outputs, so pulse is glitch-free.
    always_comb begin
        w_pulse = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_pulse[b] = edge_pulse(EDGE_MODE, w_o[b], r_o_d[b]);
        end
    end

    assign o       = w_o;
    assign pulse   = w_pulse;
    assign changed = |w_pulse;

endmodule

// File: tb/tb_ctech_lib_sync_filter.sv
// ---------------------------------------------------------------------------
// tb_ctech_lib_sync_filter
// Several parameterisations of ctech_lib_sync_filter run side by side on a
// shared clock and reset. Each has a reference model that keeps the full
// history of sampled inputs, derives the synced value as "input seen STAGES
// edges ago", and flips its level after FILTER_CYCLES consecutive
// disagreeing samples. Directed sequences check the latency/glitch/reset
// scenarios with hard-coded cycle numbers; a random phase then stresses all
// configurations against the models.
// ---------------------------------------------------------------------------
module tb_ctech_lib_sync_filter;
    import ctech_lib_sync_pkg::*;

    localparam int NCFG = 7;
    localparam int         CFG_W [NCFG] = '{1, 1, 1, 4, 2, 4, 3};
    localparam int         CFG_S [NCFG] = '{3, 3, 2, 3, 3, 4, 2};
    localparam int         CFG_F [NCFG] = '{0, 0, 4, 0, 8, 3, 1};
    localparam logic       CFG_R [NCFG] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam edge_mode_e CFG_M [NCFG] = '{RISE, BOTH, RISE, BOTH, RISE, FALL, NONE};

    logic       clk;
    logic       rst;
    logic [3:0] d_all [NCFG];

    int n_checks;
    int n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int         W = CFG_W[g];
        localparam int         S = CFG_S[g];
        localparam int         F = CFG_F[g];
        localparam logic       R = CFG_R[g];
        localparam edge_mode_e M = CFG_M[g];

        logic [W-1:0] d_s;
        logic [W-1:0] o_s;
        logic [W-1:0] pulse_s;
        logic         changed_s;

        logic [W-1:0] m_o;
        logic [W-1:0] m_pulse;
        logic [W-1:0] m_hist [$];
        int           m_run [W];

        assign d_s = d_all[g][W-1:0];

        ctech_lib_sync_filter #(
            .WIDTH         (W),
            .STAGES        (S),
            .RST_VAL       (R),
            .FILTER_CYCLES (F),
            .EDGE_MODE     (M)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .d       (d_s),
            .o       (o_s),
            .pulse   (pulse_s),
            .changed (changed_s)
        );

        // Synced value after n edges since reset release: the input sampled S edges earlier.
        function automatic logic [W-1:0] sync_at(int n);
            if (n >= S) return m_hist[n-S];
            return {W{R}};
        endfunction

        // Reference model, advanced once per clock edge or on reset.
        initial begin : model
            logic [W-1:0] s_prev;
            logic [W-1:0] o_prev;
            m_o     = {W{R}};
            m_pulse = '0;
            for (int b = 0; b < W; b++) m_run[b] = 0;
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    m_o     = {W{R}};
                    m_pulse = '0;
                    m_hist.delete();
                    for (int b = 0; b < W; b++) m_run[b] = 0;
                end else begin
                    s_prev = sync_at(m_hist.size());
                    m_hist.push_back(d_s);
                    o_prev = m_o;
                    if (F == 0) begin
                        m_o = sync_at(m_hist.size());
                    end else begin
                        for (int b = 0; b < W; b++) begin
                            if (s_prev[b] != m_o[b]) begin
                                m_run[b]++;
                                if (m_run[b] == F) begin
                                    m_o[b]   = s_prev[b];
                                    m_run[b] = 0;
                                end
                            end else begin
                                m_run[b] = 0;
                            end
                        end
                    end
                    case (M)
                        RISE:    m_pulse = m_o & ~o_prev;
                        FALL:    m_pulse = ~m_o & o_prev;
                        BOTH:    m_pulse = m_o ^ o_prev;
                        default: m_pulse = '0;
                    endcase
                end
            end
        end

        // Compare every cycle, away from the active edge.
        initial begin : checker_loop
            forever begin
                @(posedge clk);
                #1;
                check_val($sformatf("cfg%0d_o", g),       32'(o_s),       32'(m_o));
                check_val($sformatf("cfg%0d_pulse", g),   32'(pulse_s),   32'(m_pulse));
                check_val($sformatf("cfg%0d_changed", g), 32'(changed_s), 32'(|m_pulse));
            end
        end
    end

    task automatic set_all_d(input logic [3:0] v);
        for (int g = 0; g < NCFG; g++) d_all[g] = v;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_all_d(4'hF);

        // Reset held with d=1
        repeat (4) @(negedge clk);
        check_val("rst_o_c0", 32'(g_cfg[0].o_s), 32'd0);
        check_val("rst_o_c1", 32'(g_cfg[1].o_s), 32'd1);
        check_val("rst_o_c5", 32'(g_cfg[5].o_s), 32'hF);
        check_val("rst_chg_c0", 32'(g_cfg[0].changed_s), 32'd0);
        rst = 1'b0;

        // Release with d!=RST_VAL: latency STAGES (cfg0), STAGES+F (cfg2), none for cfg1
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("lat_c0_o_e%0d", e),   32'(g_cfg[0].o_s),       (e >= 3) ? 32'd1 : 32'd0);
            check_val($sformatf("lat_c0_p_e%0d", e),   32'(g_cfg[0].pulse_s),   (e == 3) ? 32'd1 : 32'd0);
            check_val($sformatf("lat_c0_chg_e%0d", e), 32'(g_cfg[0].changed_s), (e == 3) ? 32'd1 : 32'd0);
            check_val($sformatf("rv_c1_o_e%0d", e),    32'(g_cfg[1].o_s),       32'd1);
            check_val($sformatf("rv_c1_p_e%0d", e),    32'(g_cfg[1].pulse_s),   32'd0);
            check_val($sformatf("lat_c2_o_e%0d", e),   32'(g_cfg[2].o_s),       (e >= 6) ? 32'd1 : 32'd0);
        end

        // Settle low, then a 3-clock glitch: cfg2 (F=4) must not move
        @(negedge clk);
        set_all_d(4'h0);
        repeat (16) @(negedge clk);
        set_all_d(4'hF);
        repeat (3) @(negedge clk);
        set_all_d(4'h0);
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("glitch_c2_o_e%0d", e), 32'(g_cfg[2].o_s), 32'd0);
        end

        // Stable change afterwards: count restarted, so exactly 6 clocks
        @(negedge clk);
        set_all_d(4'hF);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("stable_c2_o_e%0d", e), 32'(g_cfg[2].o_s), (e >= 6) ? 32'd1 : 32'd0);
        end

        // BOTH-edge pulses on cfg3: 0000 -> 0101 -> 0110
        @(negedge clk);
        d_all[3] = 4'b0000;
        repeat (8) @(negedge clk);
        d_all[3] = 4'b0101;
        for (int e = 1; e <= 7; e++) begin
            logic [3:0] exp_p;
            @(posedge clk);
            #1;
            exp_p = (e == 3) ? 4'b0101 : (e == 5) ? 4'b0011 : 4'b0000;
            check_val($sformatf("both_c3_p_e%0d", e),   32'(g_cfg[3].pulse_s),   32'(exp_p));
            check_val($sformatf("both_c3_chg_e%0d", e), 32'(g_cfg[3].changed_s), (exp_p != 4'b0000) ? 32'd1 : 32'd0);
            if (e == 2) begin
                @(negedge clk);
                d_all[3] = 4'b0110;
            end
        end

        // Reset mid-count on cfg4 (STAGES=3, F=8)
        @(negedge clk);
        set_all_d(4'h0);
        repeat (16) @(negedge clk);
        d_all[4] = 4'h3;
        repeat (8) @(negedge clk);
        check_val("midrst_c4_o_pre", 32'(g_cfg[4].o_s), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_c4_o_in", 32'(g_cfg[4].o_s),     32'd0);
        check_val("midrst_c4_p_in", 32'(g_cfg[4].pulse_s), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("midrst_c4_o_e%0d", e), 32'(g_cfg[4].o_s),     (e >= 11) ? 32'd3 : 32'd0);
            check_val($sformatf("midrst_c4_p_e%0d", e), 32'(g_cfg[4].pulse_s), (e == 11) ? 32'd3 : 32'd0);
        end

        // Random phase: alternating fast-toggling and slow segments, rare resets
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            for (int g = 0; g < NCFG; g++) begin
                if (((k / 100) % 2) == 0) begin
                    if ($urandom_range(0, 1) == 0) d_all[g] = 4'($urandom);
                end else begin
                    if ($urandom_range(0, 11) == 0) d_all[g] = 4'($urandom);
                end
            end
            rst = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
